// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
// Imported by the receiver top and its FIFO.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_rx_state_t;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef struct packed {
      logic                     err;
      logic [PS2_DATA_BITS-1:0] data;
   } ps2_rx_entry_t;

endpackage

// File: rtl/ps2_rx_fifo_mem.sv
// First-word fall-through FIFO of received PS/2 entries.
// A push while full is only accepted when a pop frees a slot that cycle.
module ps2_rx_fifo_mem
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  ps2_rx_entry_t            wdata,
   output ps2_rx_entry_t            rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   ps2_rx_entry_t  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_pop;
   logic           do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter,
// frame decoder with stall timeout, and an output byte FIFO.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    rx_data,
   output logic                          rx_err,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic                          frame_abort,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          s_clk;
   logic          s_data;
   logic          filt;
   logic          filt_d;
   logic [FW-1:0] flt_cnt;
   logic          fall;

   assign s_clk  = clk_sync[1];
   assign s_data = data_sync[1];
   assign fall   = filt_d && !filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Level flips only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt    <= 1'b1;
         filt_d  <= 1'b1;
         flt_cnt <= '0;
      end else begin
         filt_d <= filt;
         if (s_clk == filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            filt    <= s_clk;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   ps2_rx_state_t state;
   ps2_rx_state_t state_n;
   logic [2:0]    bit_idx;
   logic [2:0]    idx_n;
   logic [7:0]    shreg;
   logic [7:0]    sh_n;
   logic          acc;
   logic          acc_n;
   logic          perr;
   logic          perr_n;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_n;
   logic          abort_n;
   logic          push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bit_idx     <= '0;
         shreg       <= '0;
         acc         <= 1'b1;
         perr        <= 1'b0;
         tcnt        <= '0;
         frame_abort <= 1'b0;
      end else begin
         state       <= state_n;
         bit_idx     <= idx_n;
         shreg       <= sh_n;
         acc         <= acc_n;
         perr        <= perr_n;
         tcnt        <= tcnt_n;
         frame_abort <= abort_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = bit_idx;
      sh_n    = shreg;
      acc_n   = acc;
      perr_n  = perr;
      abort_n = 1'b0;
      push    = 1'b0;
      tcnt_n  = (state == ST_IDLE || fall) ? '0 : tcnt + 1'b1;
      case (state)
         ST_IDLE: begin
            if (fall && !s_data) begin
               state_n = ST_DATA;
               idx_n   = '0;
               acc_n   = 1'b1;
               perr_n  = 1'b0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               sh_n[bit_idx] = s_data;
               acc_n         = acc ^ s_data;
               idx_n         = bit_idx + 1'b1;
               if (bit_idx == 3'(PS2_DATA_BITS - 1)) begin
                  state_n = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               perr_n  = (s_data != acc);
               state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               push    = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // Stalled frame: abort registers together with the return to IDLE.
      if (state != ST_IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n = ST_IDLE;
         abort_n = 1'b1;
         tcnt_n  = '0;
      end
   end

   ps2_rx_entry_t wdata;
   ps2_rx_entry_t head;
   logic          full;
   logic          empty;
   logic          pop;

   assign wdata.err  = perr || !s_data;
   assign wdata.data = shreg;
   assign pop        = rx_valid && rx_ready;

   ps2_rx_fifo_mem #(
      .DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign rx_valid = !empty;
   assign rx_data  = empty ? 8'h00 : head.data;
   assign rx_err   = !empty && head.err;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else begin
         overflow <= (push && full && !pop) || (overflow && !overflow_clr);
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames driven on the pins,
// expected entries queued and compared as the FIFO drains.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

   localparam int FL = 4;
   localparam int TO = 5000;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       overflow;
   logic       overflow_clr = 1'b0;
   logic       frame_abort;
   logic       busy;
   logic [2:0] fifo_count;

   int         n_cmp = 0;
   int         n_err = 0;
   int         abort_cnt = 0;
   logic [8:0] q[$];

   ps2_rx_fifo #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO),
      .FIFO_DEPTH     (FD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .rx_data      (rx_data),
      .rx_err       (rx_err),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .frame_abort  (frame_abort),
      .busy         (busy),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_abort === 1'b1) begin
         abort_cnt++;
      end
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   // Device drives data while clock is high; host samples on the fall.
   task automatic send_bit(logic b, int half, bit glitch);
      ps2_data = b;
      cyc(half / 2);
      if (glitch) begin
         ps2_clk = 1'b0;
         cyc(3);
         ps2_clk = 1'b1;
      end
      cyc(half - half / 2);
      ps2_clk = 1'b0;
      cyc(half);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(logic [7:0] d, logic par, logic stp,
                             int half, bit glitch, bit expect_push);
      send_bit(1'b0, half, glitch);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i], half, glitch);
      end
      send_bit(par, half, glitch);
      send_bit(stp, half, glitch);
      ps2_data = 1'b1;
      cyc(20);
      if (expect_push) begin
         q.push_back({(par != ~^d) || !stp, d});
      end
   endtask

   task automatic send_ok(logic [7:0] d, int half, bit glitch, bit expect_push);
      send_frame(d, ~^d, 1'b1, half, glitch, expect_push);
   endtask

   task automatic send_partial(int nbits, int half);
      send_bit(1'b0, half, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         send_bit(i[0], half, 1'b0);
      end
   endtask

   task automatic pop_one();
      logic [8:0] e;
      e = q.pop_front();
      check("valid", {31'd0, rx_valid}, 32'd1);
      check("data", {24'd0, rx_data}, {24'd0, e[7:0]});
      check("err", {31'd0, rx_err}, {31'd0, e[8]});
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
   endtask

   task automatic drain();
      while (q.size() > 0) begin
         pop_one();
      end
      check("drained_valid", {31'd0, rx_valid}, 32'd0);
      check("drained_count", {29'd0, fifo_count}, 32'd0);
   endtask

   task automatic check_reset_vals(string tag);
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
      check({tag, "_err"}, {31'd0, rx_err}, 32'd0);
      check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
      check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
      check({tag, "_abort"}, {31'd0, frame_abort}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(5);
      check_reset_vals("rst");
      rst_n = 1'b1;
      cyc(5);

      send_ok(8'h1C, 1000, 1'b0, 1'b1);
      check("1c_count", {29'd0, fifo_count}, 32'd1);
      drain();

      send_frame(8'hF0, 1'b0, 1'b1, 100, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b0, 100, 1'b0, 1'b1);
      check("f0_count", {29'd0, fifo_count}, 32'd2);
      drain();

      send_ok(8'h5A, 100, 1'b1, 1'b1);
      check("glitch_count", {29'd0, fifo_count}, 32'd1);
      drain();

      abort_cnt = 0;
      send_partial(4, 100);
      check("partial_busy", {31'd0, busy}, 32'd1);
      cyc(TO + 1000);
      check("abort_pulses", abort_cnt, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_count", {29'd0, fifo_count}, 32'd0);
      send_ok(8'h5A, 100, 1'b0, 1'b1);
      drain();

      for (int i = 1; i <= 5; i++) begin
         send_ok(8'(i), 100, 1'b0, i <= FD);
      end
      check("ovf_count", {29'd0, fifo_count}, 32'd4);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      drain();
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      check("ovf_clr", {31'd0, overflow}, 32'd0);

      send_ok(8'h11, 100, 1'b0, 1'b0);
      send_ok(8'h22, 100, 1'b0, 1'b0);
      check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
      send_partial(3, 100);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      ps2_data = 1'b1;
      cyc(2);
      check_reset_vals("midrst");
      rst_n = 1'b1;
      cyc(5);
      send_ok(8'h29, 100, 1'b0, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver running entirely in the system clock domain. It synchronises and glitch-filters the raw `ps2_clk`/`ps2_data` pins, decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop), detects stalled frames by timeout, and buffers received bytes with a per-byte error flag in a FIFO. The FIFO is drained through a valid/ready handshake. It sits between the board PS/2 pins and the keyboard/mouse peripheral bus logic.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before filtered `ps2_clk` changes level (≥1).
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a filtered falling edge before an in-progress frame is aborted.
- `FIFO_DEPTH`, 8: entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous.
- `rx_data`  out  8  byte at FIFO head; valid only while `rx_valid`.
- `rx_err`  out  1  head entry had a parity or stop-bit error.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head when `rx_valid && rx_ready`.
- `overflow`  out  1  sticky: a completed frame was dropped because the FIFO was full.
- `overflow_clr`  in  1  clears `overflow`; a same-cycle new overflow wins (stays 1).
- `frame_abort`  out  1  one-cycle pulse when a frame times out.
- `busy`  out  1  receive FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input conditioning: both pins pass through 2-FF synchronisers. Synchronised `ps2_clk` feeds a filter: the filtered level takes the new value only after `FILTER_LEN` consecutive equal samples. A falling edge of the filtered clock produces a one-cycle `fall` strobe. Synchronised `ps2_data` is sampled on `fall`. Filter resets to level 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA, bit index 0, parity accumulator 1. On `fall` with data=1, remain in IDLE (no push, no flag).
  - DATA: on each `fall`, store bit at index and XOR it into the accumulator. After index 7, go to PARITY.
  - PARITY: on `fall`, record mismatch if sample ≠ accumulator, then go to STOP.
  - STOP: on `fall`, push {err, byte} with err = parity mismatch OR stop sample==0, then go to IDLE.
- Timeout: a counter clears on every `fall` and on entry to IDLE, and increments while not in IDLE. On reaching `TIMEOUT_CYCLES`: pulse `frame_abort`, go to IDLE, discard partial data, no push.
- FIFO: first-word fall-through. Pop on `rx_valid && rx_ready`.
  - Push while full and no pop: entry dropped, `overflow` set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push while empty: visible the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset (any time, including mid-frame): FSM IDLE, FIFO empty, counters 0, synchronisers and filter at 1.
  - Output values in reset: `rx_valid`=0, `rx_err`=0, `rx_data`=0, `overflow`=0, `frame_abort`=0, `busy`=0, `fifo_count`=0.

## Timing
- Pin edge to `fall` strobe: 2 sync cycles + `FILTER_LEN` cycles + 1.
- The stop-bit `fall` cycle writes the FIFO at that clock edge. `rx_valid` and `fifo_count` update in the next cycle.
- `rx_valid` stays high, with head entry stable, until popped. Popping the last entry drops `rx_valid` in the next cycle.
- `frame_abort` is high exactly one cycle. `busy` drops in the same cycle as the abort.
- `overflow_clr` takes effect in the next cycle.

## Structure
- Package `ps2_pkg` holds:
  - the state enum `ps2_rx_state_t`;
  - frame constants: `PS2_DATA_BITS`=8, `PS2_FRAME_BITS`=11;
  - the entry typedef `ps2_rx_entry_t` = {err, data[7:0]}.
- One sub-module: `ps2_rx_fifo_mem`, a parametrised FWFT synchronous FIFO of `ps2_rx_entry_t` providing count, full and empty. Synchroniser, filter and FSM are in the top module.

## Test plan
- Frame 0x1C, parity 0, stop 1, bit period 2000 cycles, `rx_ready`=0 → one entry: `rx_data`=0x1C, `rx_err`=0, `fifo_count`=1. Pulse `rx_ready` → `rx_valid`=0 next cycle.
- Frame 0xF0 with parity 0 (wrong) → entry 0xF0 with `rx_err`=1. Frame 0xF0 with parity 1 and stop 0 → `rx_err`=1.
- With `FILTER_LEN`=4, inject 3-cycle low glitches on `ps2_clk` within a valid 0x5A frame → received 0x5A, `rx_err`=0, no extra bits.
- With `TIMEOUT_CYCLES`=5000, send start + 4 bits then idle → `frame_abort` pulses once, `busy`=0, no push. The following 0x5A frame is received correctly.
- With `FIFO_DEPTH`=4 and `rx_ready`=0, send 0x01..0x05 → `fifo_count`=4, `overflow`=1. Drain yields 0x01..0x04 in order. `overflow_clr` clears the flag.
- Assert `rst_n`=0 mid-frame with 2 entries queued → all outputs at reset values. After release, a 0x29 frame is received correctly.
